// File: rtl/ascon_perm_sequencer.sv
// Ascon permutation sequencer: loads a 320-bit state and applies p^n one
// round per clock (two rounds per clock when ASCON_PERM_UNROLL2_EN is
// defined), with a start/ready/busy/done handshake towards the mode FSM.
// Optional build macro: ASCON_PERM_UNROLL2_EN (two chained round datapaths).
module ascon_perm_sequencer #(
  parameter int MAX_ROUNDS = 12,
  parameter int CNT_W      = 4
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [3:0]           nb_rounds_i,
  input  logic [4:0][63:0]     state_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4:0][63:0]     state_o,
  output logic [CNT_W-1:0]     round_o
);

  // One-hot encoding so each handshake output is a register bit directly.
  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_RUN  = 3'b010;
  localparam logic [2:0] S_DONE = 3'b100;

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_ROUNDS);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);
`ifdef ASCON_PERM_UNROLL2_EN
  localparam logic [CNT_W-1:0] LP_STEP = CNT_W'(2);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MAX_ROUNDS - 2);
`else
  localparam logic [CNT_W-1:0] LP_STEP = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MAX_ROUNDS - 1);
`endif

  logic [2:0]          r_fsm;
  logic [4:0][63:0]    r_state;
  logic [CNT_W-1:0]    r_round;

  logic [4:0][63:0]    w_round1;
  logic [4:0][63:0]    w_next_state;
  logic [CNT_W-1:0]    w_n;
  logic [CNT_W-1:0]    w_n_eff;
  logic [CNT_W-1:0]    w_first;

  // 64-bit rotate right by a constant amount.
  function automatic logic [63:0] f_ror(input logic [63:0] x, input int unsigned k);
    f_ror = (x >> k) | (x << (32'd64 - k));
  endfunction

  // One full Ascon round: constant addition, bitsliced S-box layer, linear layer.
  function automatic logic [4:0][63:0] f_round(input logic [4:0][63:0] s,
                                               input logic [CNT_W-1:0] r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [3:0]  r4;
    r4 = 4'(r);
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, 4'hF - r4, r4};
    x3 = s[3];
    x4 = s[4];
    // S-box applied to all 64 columns at once; column bit order is x0..x4 MSB..LSB
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    // Linear diffusion per word
    f_round[0] = x0 ^ f_ror(x0, 19) ^ f_ror(x0, 28);
    f_round[1] = x1 ^ f_ror(x1, 61) ^ f_ror(x1, 39);
    f_round[2] = x2 ^ f_ror(x2, 1)  ^ f_ror(x2, 6);
    f_round[3] = x3 ^ f_ror(x3, 10) ^ f_ror(x3, 17);
    f_round[4] = x4 ^ f_ror(x4, 7)  ^ f_ror(x4, 41);
  endfunction

  // Round datapath: purely combinational from the state register and round index.
  always_comb begin
    w_round1 = f_round(r_state, r_round);
`ifdef ASCON_PERM_UNROLL2_EN
    w_next_state = f_round(w_round1, r_round + LP_ONE);
`else
    w_next_state = w_round1;
`endif
  end

  // Legalise the requested round count and derive the starting round index.
  always_comb begin
    if ((nb_rounds_i == 4'd0) || ({28'd0, nb_rounds_i} > 32'(MAX_ROUNDS))) begin
      w_n = LP_MAX;
    end else begin
      w_n = CNT_W'(nb_rounds_i);
    end
`ifdef ASCON_PERM_UNROLL2_EN
    // Two rounds per cycle: odd counts round down, and zero falls back to the maximum.
    if (w_n[CNT_W-1:1] == {(CNT_W-1){1'b0}}) begin
      w_n_eff = LP_MAX;
    end else begin
      w_n_eff = {w_n[CNT_W-1:1], 1'b0};
    end
`else
    w_n_eff = w_n;
`endif
    w_first = LP_MAX - w_n_eff;
  end

  // Control FSM, state register and round counter.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_round <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (start_i) begin
            r_state <= state_i;
            r_round <= w_first;
            r_fsm   <= S_RUN;
          end else begin
            r_fsm   <= S_IDLE;
          end
        end
        S_RUN: begin
          r_state <= w_next_state;
          if (r_round == LP_LAST) begin
            r_fsm   <= S_DONE;
          end else begin
            r_round <= r_round + LP_STEP;
          end
        end
        S_DONE: begin
          r_fsm <= S_IDLE;
        end
        default: begin
          r_fsm <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o = r_fsm[0];
  assign busy_o  = r_fsm[1];
  assign done_o  = r_fsm[2];
  assign state_o = r_state;
  assign round_o = r_round;

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Directed bench for ascon_perm_sequencer. Golden permutation results come
// from a table-driven S-box / bitwise-rotation reference model in this file.
module tb_ascon_perm_sequencer;

  typedef logic [4:0][63:0] st_t;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [3:0]  nb_rounds_i;
  st_t         state_i;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  st_t         state_o;
  logic [3:0]  round_o;

  int checks = 0;
  int failures = 0;

  localparam logic [4:0] SBOX [0:31] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

`ifdef ASCON_PERM_UNROLL2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  st_t iv;

  ascon_perm_sequencer dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .nb_rounds_i (nb_rounds_i),
    .state_i     (state_i),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .state_o     (state_o),
    .round_o     (round_o)
  );

  always #5 clock_i = ~clock_i;

  // ---------------- reference model ----------------
  function automatic st_t m_round(st_t s, int r);
    st_t a, b, res;
    logic [4:0] v, y;
    int ra [5];
    int rb [5];
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    a = s;
    a[2][7:0] = a[2][7:0] ^ {4'(15 - r), 4'(r)};
    b = a;
    for (int i = 0; i < 64; i++) begin
      v = {a[0][i], a[1][i], a[2][i], a[3][i], a[4][i]};
      y = SBOX[v];
      b[0][i] = y[4]; b[1][i] = y[3]; b[2][i] = y[2]; b[3][i] = y[1]; b[4][i] = y[0];
    end
    for (int w = 0; w < 5; w++) begin
      for (int j = 0; j < 64; j++) begin
        res[w][j] = b[w][j] ^ b[w][(j + ra[w]) % 64] ^ b[w][(j + rb[w]) % 64];
      end
    end
    return res;
  endfunction

  function automatic int m_eff(int nb);
    int n;
    n = (nb == 0 || nb > 12) ? 12 : nb;
`ifdef ASCON_PERM_UNROLL2_EN
    n = n & ~1;
    if (n == 0) n = 12;
`endif
    return n;
  endfunction

  function automatic int m_lat(int nb);
    return m_eff(nb) / STEP;
  endfunction

  function automatic int m_first(int nb);
    return 12 - m_eff(nb);
  endfunction

  function automatic st_t m_step(st_t s, int r);
`ifdef ASCON_PERM_UNROLL2_EN
    return m_round(m_round(s, r), r + 1);
`else
    return m_round(s, r);
`endif
  endfunction

  function automatic st_t m_perm(st_t s, int nb);
    st_t t;
    t = s;
    for (int r = 12 - m_eff(nb); r < 12; r++) t = m_round(t, r);
    return t;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic start_perm(input logic [3:0] nb, input st_t st);
    start_i = 1'b1; nb_rounds_i = nb; state_i = st;
    @(posedge clock_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock_i); #1;
      if (done_o === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_i = 1'b1; start_i = 1'b0; nb_rounds_i = 4'd0; state_i = '0;
    #2;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    checks++; if ({busy_o, done_o} !== 2'b00) begin failures++; $display("FAIL reset_busy_done: got %b expected 00", {busy_o, done_o}); end
    checks++; if (state_o !== '0) begin failures++; $display("FAIL reset_state: got %h expected 0", state_o); end
    checks++; if (round_o !== 4'd0) begin failures++; $display("FAIL reset_round: got %0d expected 0", round_o); end
    @(posedge clock_i); #4 reset_i = 1'b0;
    @(posedge clock_i); #1;
    start_perm(4'd12, iv);
    repeat (3) @(posedge clock_i);
    #4 reset_i = 1'b1;
    #1;
    checks++; if (state_o !== '0) begin failures++; $display("FAIL async_reset_state: got %h expected 0", state_o); end
    checks++; if (round_o !== 4'd0) begin failures++; $display("FAIL async_reset_round: got %0d expected 0", round_o); end
    checks++; if ({ready_o, busy_o, done_o} !== 3'b100) begin failures++; $display("FAIL async_reset_flags: got %b expected 100", {ready_o, busy_o, done_o}); end
    #2 reset_i = 1'b0;
    @(posedge clock_i); #1;
    checks++; if ({ready_o, busy_o} !== 2'b10) begin failures++; $display("FAIL post_reset_idle: got %b expected 10", {ready_o, busy_o}); end
  endtask

  task automatic test_p12;
    st_t exp;
    exp = m_perm(iv, 12);
    start_perm(4'd12, iv);
    checks++; if ({busy_o, round_o} !== {1'b1, 4'd0}) begin failures++; $display("FAIL p12_accept: got busy=%b round=%0d expected busy=1 round=0", busy_o, round_o); end
    for (int c = 1; c < m_lat(12); c++) begin
      @(posedge clock_i); #1;
      checks++;
      if ({busy_o, done_o, round_o} !== {1'b1, 1'b0, 4'(c * STEP)}) begin
        failures++; $display("FAIL p12_round_seq: got busy=%b done=%b round=%0d expected busy=1 done=0 round=%0d", busy_o, done_o, round_o, c * STEP);
      end
    end
    @(posedge clock_i); #1;
    checks++; if ({done_o, busy_o, ready_o} !== 3'b100) begin failures++; $display("FAIL p12_done_flags: got %b expected 100", {done_o, busy_o, ready_o}); end
    checks++; if (state_o !== exp) begin failures++; $display("FAIL p12_state: got %h expected %h", state_o, exp); end
    @(posedge clock_i); #1;
    checks++; if ({done_o, ready_o} !== 2'b01) begin failures++; $display("FAIL p12_back_idle: got %b expected 01", {done_o, ready_o}); end
    checks++; if (state_o !== exp) begin failures++; $display("FAIL p12_state_hold: got %h expected %h", state_o, exp); end
  endtask

  task automatic test_p6_zero;
    st_t zero, exp1;
    int lat;
    zero = '0;
    exp1 = m_step(zero, m_first(6));
    start_perm(4'd6, zero);
    checks++; if (round_o !== 4'(m_first(6))) begin failures++; $display("FAIL p6_first_round: got %0d expected %0d", round_o, m_first(6)); end
    @(posedge clock_i); #1;
    checks++; if (state_o !== exp1) begin failures++; $display("FAIL p6_first_cycle: got %h expected %h", state_o, exp1); end
    wait_done(lat);
    if (lat > 0) lat = lat + 1;
    checks++; if (lat !== m_lat(6)) begin failures++; $display("FAIL p6_latency: got %0d expected %0d", lat, m_lat(6)); end
    checks++; if (state_o !== m_perm(zero, 6)) begin failures++; $display("FAIL p6_state: got %h expected %h", state_o, m_perm(zero, 6)); end
    @(posedge clock_i); #1;
  endtask

  task automatic test_legalise;
    logic [3:0] nbs [4];
    st_t st, exp;
    int lat;
    nbs = '{4'd0, 4'd15, 4'd1, 4'd5};
    for (int k = 0; k < 4; k++) begin
      st = iv;
      st[1] = st[1] ^ 64'(k + 1) * 64'h9e3779b97f4a7c15;
      exp = m_perm(st, int'(nbs[k]));
      start_perm(nbs[k], st);
      wait_done(lat);
      checks++; if (lat !== m_lat(int'(nbs[k]))) begin failures++; $display("FAIL legalise_latency n=%0d: got %0d expected %0d", nbs[k], lat, m_lat(int'(nbs[k]))); end
      checks++; if (state_o !== exp) begin failures++; $display("FAIL legalise_state n=%0d: got %h expected %h", nbs[k], state_o, exp); end
      @(posedge clock_i); #1;
    end
  endtask

  task automatic test_back_to_back;
    st_t a, b;
    int lat;
    bit bad_ready;
    a = iv; a[3] = 64'hdeadbeefcafef00d;
    b = iv; b[0] = 64'h0123456789abcdef;
    bad_ready = 1'b0;
    start_i = 1'b1; nb_rounds_i = 4'd6; state_i = a;
    @(posedge clock_i); #1;
    checks++; if ({busy_o, round_o} !== {1'b1, 4'(m_first(6))}) begin failures++; $display("FAIL b2b_accept1: got busy=%b round=%0d", busy_o, round_o); end
    state_i = b;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock_i); #1;
      if (done_o === 1'b1) begin lat = c; break; end
      if (ready_o !== 1'b0) bad_ready = 1'b1;
    end
    checks++; if (lat !== m_lat(6)) begin failures++; $display("FAIL b2b_latency1: got %0d expected %0d", lat, m_lat(6)); end
    checks++; if (bad_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_in_run: got %b expected 0", bad_ready); end
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL b2b_ready_in_done: got %b expected 0", ready_o); end
    checks++; if (state_o !== m_perm(a, 6)) begin failures++; $display("FAIL b2b_state1: got %h expected %h", state_o, m_perm(a, 6)); end
    @(posedge clock_i); #1;
    checks++; if ({ready_o, busy_o, done_o} !== 3'b100) begin failures++; $display("FAIL b2b_idle_gap: got %b expected 100", {ready_o, busy_o, done_o}); end
    @(posedge clock_i); #1;
    start_i = 1'b0;
    checks++; if ({busy_o, round_o} !== {1'b1, 4'(m_first(6))}) begin failures++; $display("FAIL b2b_accept2: got busy=%b round=%0d", busy_o, round_o); end
    wait_done(lat);
    checks++; if (lat !== m_lat(6)) begin failures++; $display("FAIL b2b_latency2: got %0d expected %0d", lat, m_lat(6)); end
    checks++; if (state_o !== m_perm(b, 6)) begin failures++; $display("FAIL b2b_state2: got %h expected %h", state_o, m_perm(b, 6)); end
    @(posedge clock_i); #1;
  endtask

  task automatic test_reset_mid_run;
    bit found, saw_done;
    int lat;
    found = 1'b0; saw_done = 1'b0;
    start_perm(4'd12, iv);
    for (int c = 0; c < 40; c++) begin
      if (round_o >= 4'd5) begin found = 1'b1; break; end
      @(posedge clock_i); #1;
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL midrun_reach_round5: got %b expected 1", found); end
    #3 reset_i = 1'b1;
    #1;
    checks++; if (state_o !== '0) begin failures++; $display("FAIL midrun_state_clear: got %h expected 0", state_o); end
    checks++; if ({round_o, ready_o, busy_o, done_o} !== {4'd0, 3'b100}) begin failures++; $display("FAIL midrun_ctrl_clear: got round=%0d flags=%b expected round=0 flags=100", round_o, {ready_o, busy_o, done_o}); end
    @(posedge clock_i); #4 reset_i = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clock_i); #1;
      if (done_o !== 1'b0) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL midrun_no_done: got %b expected 0", saw_done); end
    start_perm(4'd8, iv);
    wait_done(lat);
    checks++; if (lat !== m_lat(8)) begin failures++; $display("FAIL midrun_p8_latency: got %0d expected %0d", lat, m_lat(8)); end
    checks++; if (state_o !== m_perm(iv, 8)) begin failures++; $display("FAIL midrun_p8_state: got %h expected %h", state_o, m_perm(iv, 8)); end
    @(posedge clock_i); #1;
  endtask

  initial begin
    iv[0] = 64'h80400c0600000000;
    iv[1] = 64'h0001020304050607;
    iv[2] = 64'h08090a0b0c0d0e0f;
    iv[3] = 64'h0001020304050607;
    iv[4] = 64'h08090a0b0c0d0e0f;
    test_reset();
    test_p12();
    test_p6_zero();
    test_legalise();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
